// File: rtl/bird_pkg.sv
// bird_pkg: shared types and constants for the bird vertical-motion engine.
//   state_t    game state encoding seen on bird_physics.state
//   POS_FRAC   fractional bits of the Q11.4 position
//   POS_W      position register width
//   VEL_W      signed velocity width
//   SUM_W      signed width of the position + velocity intermediate
//   fall_step  gravity step with terminal-velocity saturation
package bird_pkg;

  typedef enum logic [1:0] {
    READY  = 2'd0,
    FLYING = 2'd1,
    DEAD   = 2'd2
  } state_t;

  localparam int POS_FRAC = 4;
  localparam int POS_W    = 15;
  localparam int VEL_W    = 8;
  localparam int SUM_W    = 17;

  // Add gravity to the velocity and clamp at terminal velocity. One extra
  // bit of headroom keeps the intermediate sum from wrapping.
  function automatic logic signed [VEL_W-1:0] fall_step(
    input logic signed [VEL_W-1:0] vel,
    input logic signed [VEL_W:0]   grav,
    input logic signed [VEL_W:0]   lim
  );
    logic signed [VEL_W:0] sum;
    sum = $signed({vel[VEL_W-1], vel}) + grav;
    if (sum > lim) begin
      fall_step = lim[VEL_W-1:0];
    end else begin
      fall_step = sum[VEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bird_click_latch.sv
// bird_click_latch: remembers a flap request until the next frame tick.
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   set    in   1-cycle click request
//   clear  in   frame tick, consumes the stored request
//   flush  in   drop any stored request (game reset, death)
//   take   out  request visible to the current tick (stored or arriving now)
module bird_click_latch (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clear,
  input  logic flush,
  output logic take
);

  logic pending_r;

  // Stored-request flag; a click arriving on the tick cycle is consumed by
  // that tick through 'take', so the flag clears rather than sets.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (flush) begin
      pending_r <= 1'b0;
    end else if (clear) begin
      pending_r <= 1'b0;
    end else if (set) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign take = pending_r | set;

endmodule

// File: rtl/bird_physics.sv
// bird_physics: per-frame gravity/flap integrator and game state for the bird.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   click_pulse  in   1-cycle flap request
//   frame_tick   in   1-cycle pulse once per frame
//   collide      in   level from the collision detector
//   game_reset   in   1-cycle pulse, return to READY
//   bird_y       out  bird top row, integer px
//   bird_vel     out  signed velocity, 1/16 px/frame
//   state        out  game state
//   flap_evt     out  pulse in the cycle a flap velocity first shows on bird_vel
//   dead         out  high while in DEAD
// Optional feature macro: FLAP_COOLDOWN_EN (flap lockout for COOLDOWN_FRAMES
// ticks after each flap; COOLDOWN_FRAMES exists only when it is defined).
module bird_physics
  import bird_pkg::*;
#(
  parameter int SCREEN_H = 768,
  parameter int BIRD_H   = 32,
  parameter int Y_START  = 368,
  parameter int GRAVITY  = 6,
  parameter int FLAP_VEL = -72,
  parameter int MAX_FALL = 112
`ifdef FLAP_COOLDOWN_EN
  ,
  parameter int COOLDOWN_FRAMES = 4
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       click_pulse,
  input  logic                       frame_tick,
  input  logic                       collide,
  input  logic                       game_reset,
  output logic [POS_W-POS_FRAC-1:0]  bird_y,
  output logic [VEL_W-1:0]           bird_vel,
  output state_t                     state,
  output logic                       flap_evt,
  output logic                       dead
);

  localparam logic [POS_W-1:0]        POS_START = POS_W'(Y_START << POS_FRAC);
  localparam logic signed [SUM_W-1:0] POS_FLOOR = SUM_W'((SCREEN_H - BIRD_H) << POS_FRAC);
  localparam logic signed [VEL_W-1:0] VEL_FLAP  = VEL_W'(FLAP_VEL);
  localparam logic signed [VEL_W:0]   VEL_GRAV  = (VEL_W+1)'(GRAVITY);
  localparam logic signed [VEL_W:0]   VEL_MAX   = (VEL_W+1)'(MAX_FALL);

  state_t                  state_r, state_next;
  logic [POS_W-1:0]        pos_r, pos_next;
  logic signed [VEL_W-1:0] vel_r, vel_next;
  logic                    flap_evt_r, flap_evt_next;
  logic                    dead_r, dead_next;

  logic                    take;
  logic                    flush;
  logic                    blocked;
  logic                    do_flap;
  logic                    tick_applies;

  logic signed [VEL_W-1:0] vel_cand;
  logic signed [SUM_W-1:0] pos_sum;
  logic                    phys_ceiling;
  logic                    phys_floor;
  logic [POS_W-1:0]        phys_pos;
  logic signed [VEL_W-1:0] phys_vel;

  bird_click_latch u_click_latch (
    .clk   (clk),
    .rst   (rst),
    .set   (click_pulse),
    .clear (frame_tick),
    .flush (flush),
    .take  (take)
  );

`ifdef FLAP_COOLDOWN_EN
  localparam int CD_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  logic [CD_W-1:0] cd_r, cd_next;

  // Cooldown counter next value: loads on a flap, counts ticks down to zero.
  always_comb begin
    if (game_reset || (state_next == DEAD)) begin
      cd_next = {CD_W{1'b0}};
    end else if (tick_applies && do_flap) begin
      cd_next = CD_W'(COOLDOWN_FRAMES);
    end else if (tick_applies && (cd_r != {CD_W{1'b0}})) begin
      cd_next = cd_r - CD_W'(1);
    end else begin
      cd_next = cd_r;
    end
  end

  // Cooldown counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd_r <= {CD_W{1'b0}};
    end else begin
      cd_r <= cd_next;
    end
  end

  assign blocked = (cd_r != {CD_W{1'b0}});
`else
  assign blocked = 1'b0;
`endif

  // Candidate physics update for a tick; a blocked click falls back to gravity.
  always_comb begin
    do_flap = take & ~blocked;
    if (do_flap) begin
      vel_cand = VEL_FLAP;
    end else begin
      vel_cand = fall_step(vel_r, VEL_GRAV, VEL_MAX);
    end
    pos_sum = $signed({{(SUM_W-POS_W){1'b0}}, pos_r})
            + $signed({{(SUM_W-VEL_W){vel_cand[VEL_W-1]}}, vel_cand});
    phys_ceiling = pos_sum[SUM_W-1];
    phys_floor   = ~phys_ceiling & (pos_sum >= POS_FLOOR);
    if (phys_ceiling) begin
      // Hitting the top stops the bird dead against the ceiling.
      phys_pos = {POS_W{1'b0}};
      phys_vel = {VEL_W{1'b0}};
    end else if (phys_floor) begin
      phys_pos = POS_FLOOR[POS_W-1:0];
      phys_vel = vel_cand;
    end else begin
      phys_pos = pos_sum[POS_W-1:0];
      phys_vel = vel_cand;
    end
  end

  // Game state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= READY;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; game_reset outranks every other input.
  always_comb begin
    state_next   = state_r;
    tick_applies = 1'b0;
    if (game_reset) begin
      state_next = READY;
    end else begin
      case (state_r)
        READY: begin
          if (frame_tick && take) begin
            tick_applies = 1'b1;
            state_next   = phys_floor ? DEAD : FLYING;
          end else begin
            state_next = READY;
          end
        end
        FLYING: begin
          // Collision discards any tick update landing in the same cycle.
          if (collide) begin
            state_next = DEAD;
          end else if (frame_tick) begin
            tick_applies = 1'b1;
            state_next   = phys_floor ? DEAD : FLYING;
          end else begin
            state_next = FLYING;
          end
        end
        DEAD: begin
          state_next = DEAD;
        end
        default: begin
          state_next = READY;
        end
      endcase
    end
  end

  // Next values of the registered outputs and the click-latch flush.
  always_comb begin
    pos_next      = pos_r;
    vel_next      = vel_r;
    flap_evt_next = 1'b0;
    if (game_reset) begin
      pos_next = POS_START;
      vel_next = {VEL_W{1'b0}};
    end else if (tick_applies) begin
      pos_next = phys_pos;
      vel_next = phys_vel;
      // A flap zeroed by the ceiling never shows on bird_vel, so no event.
      flap_evt_next = do_flap & ~phys_ceiling;
    end else begin
      pos_next = pos_r;
      vel_next = vel_r;
    end
    dead_next = (state_next == DEAD);
    flush     = game_reset | (state_r == DEAD) | (state_next == DEAD);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_r      <= POS_START;
      vel_r      <= {VEL_W{1'b0}};
      flap_evt_r <= 1'b0;
      dead_r     <= 1'b0;
    end else begin
      pos_r      <= pos_next;
      vel_r      <= vel_next;
      flap_evt_r <= flap_evt_next;
      dead_r     <= dead_next;
    end
  end

  assign bird_y   = pos_r[POS_W-1:POS_FRAC];
  assign bird_vel = vel_r;
  assign state    = state_r;
  assign flap_evt = flap_evt_r;
  assign dead     = dead_r;

endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed and randomized bench for bird_physics with an
// integer-arithmetic reference model of the bird's per-frame motion.
module tb_bird_physics;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              click_pulse = 1'b0;
  logic              frame_tick = 1'b0;
  logic              collide = 1'b0;
  logic              game_reset = 1'b0;
  logic [10:0]       bird_y;
  logic [7:0]        bird_vel;
  bird_pkg::state_t  state;
  logic              flap_evt;
  logic              dead;

  always #5 clk = ~clk;

  bird_physics dut (
    .clk         (clk),
    .rst         (rst),
    .click_pulse (click_pulse),
    .frame_tick  (frame_tick),
    .collide     (collide),
    .game_reset  (game_reset),
    .bird_y      (bird_y),
    .bird_vel    (bird_vel),
    .state       (state),
    .flap_evt    (flap_evt),
    .dead        (dead)
  );

`ifdef FLAP_COOLDOWN_EN
  localparam bit CD_EN = 1'b1;
`else
  localparam bit CD_EN = 1'b0;
`endif

  // Reference model: state 0/1/2, position in 1/16 px, velocity in 1/16 px/frame.
  int m_state   = 0;
  int m_pos     = 368 * 16;
  int m_vel     = 0;
  int m_cd      = 0;
  bit m_pending = 1'b0;
  bit m_flap    = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int flap_cnt = 0;

  task automatic model_step();
    int st, p, v, cd;
    bit pend, fl, take, want;
    st = m_state; p = m_pos; v = m_vel; cd = m_cd; pend = m_pending; fl = 1'b0;
    take = pend || click_pulse;
    if (rst) begin
      st = 0; p = 368 * 16; v = 0; cd = 0; pend = 1'b0;
    end else if (game_reset) begin
      st = 0; p = 368 * 16; v = 0; cd = 0; pend = 1'b0;
    end else if (st == 1 && collide) begin
      st = 2; cd = 0; pend = 1'b0;
    end else if (frame_tick && (st == 1 || (st == 0 && take))) begin
      want = take && !(CD_EN && cd > 0);
      if (want) v = -72;
      else v = (v + 6 > 112) ? 112 : v + 6;
      if (cd > 0) cd = cd - 1;
      if (want) cd = 4;
      if (!CD_EN) cd = 0;
      p  = p + v;
      st = 1;
      fl = want;
      if (p < 0) begin
        p = 0; v = 0; fl = 1'b0;
      end else if (p >= 736 * 16) begin
        p = 736 * 16; st = 2; cd = 0;
      end
      pend = 1'b0;
    end else if (st == 2 || frame_tick) begin
      pend = 1'b0;
    end else begin
      pend = take;
    end
    m_state   <= st;
    m_pos     <= p;
    m_vel     <= v;
    m_cd      <= cd;
    m_pending <= pend;
    m_flap    <= fl;
  endtask

  // Advance the model on the same edge the DUT samples its inputs.
  always @(posedge clk) model_step();

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state", int'(state), m_state);
    check("bird_y", int'(bird_y), m_pos / 16);
    check("bird_vel", int'($signed(bird_vel)), m_vel);
    check("flap_evt", int'(flap_evt), int'(m_flap));
    check("dead", int'(dead), int'(m_state == 2));
  endtask

  // Drive one cycle of inputs, then compare just after the following negedge.
  task automatic step(input bit c, input bit t, input bit col, input bit gr, input bit r);
    click_pulse = c;
    frame_tick  = t;
    collide     = col;
    game_reset  = gr;
    rst         = r;
    @(negedge clk);
    compare_all();
    if (flap_evt) flap_cnt++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int cprob [4] = '{3, 12, 40, 0};

  initial begin
    int ticks;
    int y0, v0, vprev, gap;
    bit c, t, col, gr, r;

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_state", int'(state), 0);
    check("rst_y", int'(bird_y), 368);
    check("rst_vel", int'($signed(bird_vel)), 0);
    check("rst_flap", int'(flap_evt), 0);
    check("rst_dead", int'(dead), 0);

    // Ten idle frames in READY.
    flap_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(); idle(); idle(); tick();
    end
    check("idle_flaps", flap_cnt, 0);
    check("idle_state", int'(state), 0);
    check("idle_y", int'(bird_y), 368);
    check("idle_vel", int'($signed(bird_vel)), 0);

    // Click three cycles ahead of a tick launches the bird.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(); idle(); tick();
    check("launch_state", int'(state), 1);
    check("launch_vel", int'($signed(bird_vel)), -72);
    check("launch_y", int'(bird_y), 363);
    check("launch_flap", int'(flap_evt), 1);
    idle();
    check("launch_flap_pulse", int'(flap_evt), 0);

    // Free fall to terminal velocity and the floor.
    for (int k = 1; k <= 31; k++) begin
      idle(); idle(); tick();
      if (k == 30) check("vel_t30", int'($signed(bird_vel)), 108);
      if (k == 31) begin
        check("vel_t31", int'($signed(bird_vel)), 112);
        check("y_t31", int'(bird_y), 409);
      end
    end
    ticks = 31;
    while (state != bird_pkg::DEAD && ticks < 120) begin
      idle(); tick();
      ticks++;
    end
    check("ticks_to_floor", ticks, 78);
    check("floor_y", int'(bird_y), 736);
    check("floor_dead", int'(dead), 1);

    // Clicks are ignored while dead.
    flap_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(); tick(); idle();
    check("dead_click_flaps", flap_cnt, 0);
    check("dead_click_y", int'(bird_y), 736);
    check("dead_click_state", int'(state), 2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("greset_state", int'(state), 0);
    check("greset_y", int'(bird_y), 368);
    check("greset_dead", int'(dead), 0);

    // Click coinciding with a tick, in READY and then in FLYING.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("coinc_ready_state", int'(state), 1);
    check("coinc_ready_flap", int'(flap_evt), 1);
    repeat (4) begin idle(); tick(); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("coinc_fly_flap", int'(flap_evt), 1);
    check("coinc_fly_vel", int'($signed(bird_vel)), -72);
    repeat (4) begin idle(); tick(); end
    flap_cnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(); tick();
    check("double_click_vel", int'($signed(bird_vel)), -72);
    idle();
    check("double_click_flaps", flap_cnt, 1);

    // Collision together with a tick discards the tick's motion.
    y0 = int'(bird_y);
    v0 = int'($signed(bird_vel));
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("collide_state", int'(state), 2);
    check("collide_y", int'(bird_y), y0);
    check("collide_vel", int'($signed(bird_vel)), v0);
    tick();
    check("collide_frozen_y", int'(bird_y), y0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("relaunch_state", int'(state), 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("greset_over_collide_state", int'(state), 0);
    check("greset_over_collide_y", int'(bird_y), 368);

    if (CD_EN) begin
      // Flap lockout: clicks before the next four ticks only get gravity.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("cd_first_flap", int'(flap_evt), 1);
      vprev = -72;
      for (int i = 0; i < 4; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(); tick();
        vprev = vprev + 6;
        check("cd_blocked_flap", int'(flap_evt), 0);
        check("cd_blocked_vel", int'($signed(bird_vel)), vprev);
      end
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(); tick();
      check("cd_release_flap", int'(flap_evt), 1);
      check("cd_release_vel", int'($signed(bird_vel)), -72);
    end

    // Randomized phases with varying click density.
    gap = 3;
    for (int ph = 0; ph < 8; ph++) begin
      for (int i = 0; i < 2000; i++) begin
        c = (cprob[ph % 4] > 0) ? ($urandom_range(cprob[ph % 4] - 1) == 0) : 1'b0;
        t = (gap == 0);
        if (t) gap = $urandom_range(8, 2);
        else gap = gap - 1;
        col = ($urandom_range(599) == 0);
        gr  = (state == bird_pkg::DEAD) ? ($urandom_range(15) == 0) : ($urandom_range(999) == 0);
        r   = ($urandom_range(2999) == 0);
        step(c, t, col, gr, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
